// File: rtl/des_pkg.sv
// des_pkg: shared constants, the folded DES S-box table and the engine
// state type for the S-box substitution engine.
//   DES_SBOX_IN_W / DES_SBOX_OUT_W / DES_SBOX_NUM : word widths and box count
//   DES_SBOX_TABLE[box][idx]                      : 4-bit S-box value, idx is the raw 6-bit chunk
//   sbox_state_t                                  : IDLE / RUN / HOLD
//   sbox_chunk()                                  : extract the 6-bit chunk feeding a given box
package des_pkg;

  localparam int DES_SBOX_IN_W  = 48;
  localparam int DES_SBOX_OUT_W = 32;
  localparam int DES_SBOX_NUM   = 8;

  // Textbook layout: [box][row][col], leftmost nibble of each row is column 0.
  typedef logic [0:7][0:3][0:15][3:0] sbox_std_t;
  // Folded layout: [box][raw 6-bit chunk].
  typedef logic [0:7][0:63][3:0]      sbox_tab_t;

  localparam sbox_std_t DES_SBOX_STD = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE2063ADF35, 64'h21E74A8DFC90356B
  };

  // Row is {b5,b0}, column is b4..b1; folding it here lets the datapath
  // index the table with the raw chunk.
  function automatic sbox_tab_t fold_sbox(input sbox_std_t std);
    sbox_tab_t  tab;
    logic [5:0] ix;
    tab = '0;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 64; i++) begin
        ix        = 6'(i);
        tab[s][i] = std[s][{ix[5], ix[0]}][ix[4:1]];
      end
    end
    return tab;
  endfunction

  localparam sbox_tab_t DES_SBOX_TABLE = fold_sbox(DES_SBOX_STD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sbox_state_t;

  // Chunk i occupies data[47-6i -: 6] and feeds S(i+1).
  function automatic logic [5:0] sbox_chunk(input logic [47:0] data, input logic [2:0] box);
    int base;
    base = 47 - 6 * int'(box);
    return data[base -: 6];
  endfunction

endpackage

// File: rtl/des_sbox_engine_lut.sv
// des_sbox_lut: combinational 6->4 lookup into DES_SBOX_TABLE.
// The box used is SBOX_IDX + grp_i*STRIDE (mod 8), so one lane can serve
// every box it is responsible for across the groups of a word. With
// STRIDE=8 (single group) it is a plain fixed S(SBOX_IDX+1) lookup.
//   grp_i   : current group number
//   chunk_i : raw 6-bit chunk
//   nib_o   : substituted nibble
module des_sbox_lut
  import des_pkg::*;
#(
  parameter int SBOX_IDX = 0,
  parameter int STRIDE   = 8
) (
  input  logic [2:0] grp_i,
  input  logic [5:0] chunk_i,
  output logic [3:0] nib_o
);

  if (SBOX_IDX < 0 || SBOX_IDX > 7) begin : g_idx_check
    $error("des_sbox_lut: SBOX_IDX must be 0..7");
  end

  logic [2:0] box_s;

  // Select the box for this group and look up the nibble.
  always_comb begin
    box_s = 3'(SBOX_IDX + int'(grp_i) * STRIDE);
    nib_o = DES_SBOX_TABLE[box_s][chunk_i];
  end

endmodule

// File: rtl/des_sbox_engine.sv
// des_sbox_engine: DES S-box substitution layer (S1..S8), 48-bit in,
// 32-bit out, LANES boxes evaluated per cycle over GROUPS = 8/LANES cycles.
// Valid/ready on both sides; the result is held until consumed.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data sampled only on accept
//   out_valid/out_ready  : output handshake, out_data registered and held
//   busy                 : high while in RUN or HOLD
// Optional: define DES_SBOX_PARITY_EN to add out_parity (XOR of out_data).
module des_sbox_engine
  import des_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
`ifdef DES_SBOX_PARITY_EN
  ,
  output logic        out_parity
`endif
);

  localparam int GROUPS = 8 / LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  sbox_state_t state_q;
  logic [2:0]  cnt_q;     // last group written for the current word
  logic [47:0] op_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        busy_q;
`ifdef DES_SBOX_PARITY_EN
  logic        parity_q;
`endif

  logic        rdy_s;
  logic        accept_s;
  logic        last_s;
  logic [2:0]  grp_s;
  logic [47:0] src_s;
  logic [31:0] res_s;
  logic [5:0]  chunk_s [LANES];
  logic [3:0]  nib_s   [LANES];

  // Ready per state; forced low while reset is asserted.
  always_comb begin
    case (state_q)
      IDLE:    rdy_s = 1'b1;
      RUN:     rdy_s = 1'b0;
      HOLD:    rdy_s = out_ready;
      default: rdy_s = 1'b0;
    endcase
    in_ready = rst_n & rdy_s;
    accept_s = in_ready & in_valid;
  end

  // Group selection and lane operand routing. On an accept edge group 0
  // is taken straight from in_data since the operand register is loading.
  always_comb begin
    logic [2:0] box;
    grp_s  = accept_s ? 3'd0 : (cnt_q + 3'd1);
    src_s  = accept_s ? in_data : op_q;
    last_s = (grp_s == 3'(GROUPS - 1));
    res_s  = data_q;
    for (int j = 0; j < LANES; j++) begin
      box        = 3'(int'(grp_s) * LANES + j);
      chunk_s[j] = sbox_chunk(src_s, box);
      res_s[31 - 4 * int'(box) -: 4] = nib_s[j];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    des_sbox_lut #(
      .SBOX_IDX (j),
      .STRIDE   (LANES)
    ) u_lut (
      .grp_i   (grp_s),
      .chunk_i (chunk_s[j]),
      .nib_o   (nib_s[j])
    );
  end

  // Engine FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      op_q     <= 48'd0;
      data_q   <= 32'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DES_SBOX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            op_q     <= in_data;
            cnt_q    <= 3'd0;
            data_q   <= res_s;
`ifdef DES_SBOX_PARITY_EN
            parity_q <= ^res_s;
`endif
            busy_q   <= 1'b1;
            if (GROUPS == 1) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b0;
            end
          end
        end
        RUN: begin
          data_q   <= res_s;
`ifdef DES_SBOX_PARITY_EN
          parity_q <= ^res_s;
`endif
          cnt_q    <= grp_s;
          if (last_s) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (in_valid) begin
              // Simultaneous consume and accept; with one group the next
              // result is complete on this same edge.
              op_q     <= in_data;
              cnt_q    <= 3'd0;
              data_q   <= res_s;
`ifdef DES_SBOX_PARITY_EN
              parity_q <= ^res_s;
`endif
              if (GROUPS == 1) begin
                state_q <= HOLD;
                valid_q <= 1'b1;
              end else begin
                state_q <= RUN;
                valid_q <= 1'b0;
              end
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign busy       = busy_q;
`ifdef DES_SBOX_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_des_sbox_engine.sv
// Self-checking bench for des_sbox_engine: one instance per LANES value
// (1, 2, 4, 8), a table of hand-derived vectors, and a scoreboard queue
// filled on accept and drained on output transfer.
module tb_des_sbox_engine;

  logic        clk;
  logic        rst_n     [4];
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [47:0] in_data   [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] out_data  [4];
  logic        busy      [4];
`ifdef DES_SBOX_PARITY_EN
  logic        out_parity [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_engine #(
      .LANES (1 << g)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .busy       (busy[g])
`ifdef DES_SBOX_PARITY_EN
      ,
      .out_parity (out_parity[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t        tab [8];
  logic [31:0] cur_exp [4];
  logic [31:0] exp_q [$];
  logic        acc_seen;
  int          n_checks;
  int          n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: sample handshakes at the negedge, return 1ns after posedge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    acc_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        exp_q.push_back(cur_exp[i]);
        acc_seen = 1'b1;
      end
      if (out_valid[i] && out_ready[i]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: lanes=%0d got %h with nothing pending", 1 << i, out_data[i]);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("out_data_l%0d", 1 << i), out_data[i], e);
`ifdef DES_SBOX_PARITY_EN
          check($sformatf("out_parity_l%0d", 1 << i), {31'd0, out_parity[i]}, {31'd0, ^e});
`endif
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int inst);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      cycle();
      w++;
    end
    check($sformatf("drain_l%0d", 1 << inst), exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Stream 8 words with in_valid held high; alt selects zero/all-ones alternation.
  task automatic run_stream(input int inst, input bit alt);
    int total;
    int w;
    int idx;
    total = 0;
    out_ready[inst] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      idx = alt ? (k % 2) : k;
      in_data[inst]  = tab[idx].din;
      cur_exp[inst]  = tab[idx].dout;
      in_valid[inst] = 1'b1;
      w = 0;
      do begin
        cycle();
        w++;
      end while (!acc_seen && w < 50);
      if (!acc_seen) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout_l%0d: word %0d not accepted in %0d cycles", 1 << inst, k, w);
      end
      total += w;
    end
    in_valid[inst] = 1'b0;
    check($sformatf("accept_cycles_l%0d", 1 << inst), 32'(total), 32'(1 + 7 * (8 >> inst)));
    drain(inst);
  endtask

  initial begin
    int w;
    n_checks = 0;
    n_fail   = 0;
    acc_seen = 1'b0;
    tab[0] = '{din: 48'h0000_0000_0000, dout: 32'hEFA72C4D};
    tab[1] = '{din: 48'hFFFF_FFFF_FFFF, dout: 32'hD9CE3DCB};
    tab[2] = '{din: 48'h0000_0004_0000, dout: 32'hEFA7EC4D};  // S5 chunk = 1
    tab[3] = '{din: 48'h0000_0040_0000, dout: 32'hEFA78C4D};  // S5 chunk = 16
    tab[4] = '{din: 48'h0400_0000_0000, dout: 32'h0FA72C4D};  // S1 chunk = 1
    tab[5] = '{din: 48'h0000_0000_003F, dout: 32'hEFA72C4B};  // S8 chunk = 63
    tab[6] = '{din: 48'h8208_2082_0820, dout: 32'h40DA4917};  // all chunks 32
    tab[7] = '{din: 48'h0820_8208_2082, dout: 32'h410DC1B2};  // all chunks 2

    for (int i = 0; i < 4; i++) begin
      rst_n[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      in_data[i]   = 48'd0;
      out_ready[i] = 1'b1;
      cur_exp[i]   = 32'd0;
    end
    @(posedge clk);
    #1;
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_out_valid_l%0d", 1 << i), {31'd0, out_valid[i]}, 32'd0);
      check($sformatf("rst_busy_l%0d", 1 << i), {31'd0, busy[i]}, 32'd0);
      check($sformatf("rst_out_data_l%0d", 1 << i), out_data[i], 32'd0);
      check($sformatf("rst_in_ready_l%0d", 1 << i), {31'd0, in_ready[i]}, 32'd0);
`ifdef DES_SBOX_PARITY_EN
      check($sformatf("rst_parity_l%0d", 1 << i), {31'd0, out_parity[i]}, 32'd0);
`endif
      rst_n[i] = 1'b1;
    end
    cycle();

    // LANES=8: single zero word, result visible right after the accept edge.
    in_data[3] = 48'd0; cur_exp[3] = 32'hEFA72C4D; in_valid[3] = 1'b1;
    cycle();
    in_valid[3] = 1'b0;
    check("l8_accept", {31'd0, acc_seen}, 32'd1);
    check("l8_latency_valid", {31'd0, out_valid[3]}, 32'd1);
    check("l8_latency_data", out_data[3], 32'hEFA72C4D);
    drain(3);
    check("l8_idle_valid", {31'd0, out_valid[3]}, 32'd0);
    run_stream(3, 1'b1);
    run_stream(3, 1'b0);

    // LANES=1: 7 busy cycles after accept, in_data changes ignored.
    in_data[0] = 48'd0; cur_exp[0] = 32'hEFA72C4D; in_valid[0] = 1'b1;
    cycle();
    in_valid[0] = 1'b0;
    in_data[0]  = 48'hFFFF_FFFF_FFFF;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("l1_run_in_ready_%0d", k), {31'd0, in_ready[0]}, 32'd0);
      check($sformatf("l1_run_valid_%0d", k), {31'd0, out_valid[0]}, 32'd0);
      cycle();
    end
    check("l1_done_valid", {31'd0, out_valid[0]}, 32'd1);
    check("l1_done_busy", {31'd0, busy[0]}, 32'd1);
    drain(0);
    run_stream(0, 1'b0);

    // LANES=2: back-pressure for 5 cycles with the next word waiting.
    out_ready[1] = 1'b0;
    in_data[1] = tab[1].din; cur_exp[1] = tab[1].dout; in_valid[1] = 1'b1;
    cycle();
    check("l2_accept_a", {31'd0, acc_seen}, 32'd1);
    in_data[1] = tab[6].din; cur_exp[1] = tab[6].dout;
    w = 0;
    while (!out_valid[1] && w < 20) begin
      cycle();
      w++;
    end
    check("l2_latency", 32'(w), 32'd3);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("l2_stall_valid_%0d", s), {31'd0, out_valid[1]}, 32'd1);
      check($sformatf("l2_stall_data_%0d", s), out_data[1], tab[1].dout);
      check($sformatf("l2_stall_in_ready_%0d", s), {31'd0, in_ready[1]}, 32'd0);
      cycle();
    end
    out_ready[1] = 1'b1;
    cycle();
    check("l2_accept_b", {31'd0, acc_seen}, 32'd1);
    in_valid[1] = 1'b0;
    drain(1);
    run_stream(1, 1'b0);

    // LANES=4: reset one cycle into RUN abandons the word.
    in_data[2] = tab[1].din; cur_exp[2] = tab[1].dout; in_valid[2] = 1'b1;
    cycle();
    in_valid[2] = 1'b0;
    check("l4_busy_before_rst", {31'd0, busy[2]}, 32'd1);
    rst_n[2] = 1'b0;
    cycle();
    check("l4_rst_valid", {31'd0, out_valid[2]}, 32'd0);
    check("l4_rst_busy", {31'd0, busy[2]}, 32'd0);
    check("l4_rst_data", out_data[2], 32'd0);
    check("l4_rst_in_ready", {31'd0, in_ready[2]}, 32'd0);
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_back());
    end
    rst_n[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
    end
    run_stream(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
